pcgen_ysyx: RTL and testbench

Parametrised program-counter generator for the NPC front end: holds the architectural fetch PC and offers it to the IFU over a valid/ready handshake. Computes the next PC from a prioritised set of redirect sources (trap vector, mret return, branch/jump target, sequential step). Buffers a redirect that arrives while a fetch request is stalled and checks target alignment. Sits between EXU/CSR redirect logic and the IFU.

---
 rtl/pcgen_ysyx.sv | 178 +++++++++++++++++
 tb/tb_pcgen_ysyx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcgen_ysyx.sv
// pcgen_ysyx: fetch PC generator for the NPC front end.
// Holds the architectural fetch PC and presents it to the IFU over a
// valid/ready handshake. Redirect sources are prioritised trap > mret > branch.
// A redirect that arrives while the current request is stalled is parked
// in a pending register until the request fires.
module pcgen_ysyx #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000,
  parameter int              IALIGN   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mret_pc,
  input  logic            br_valid,
  input  logic            br_jalr,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_rs1,
  input  logic [XLEN-1:0] br_imm,
  input  logic            halt,
  input  logic            pc_ready,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            misalign_valid,
  output logic [XLEN-1:0] misalign_addr
);

  // IALIGN is a power of two, so the modulo check reduces to a mask test.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pend;
  logic            halt_req;

  logic [XLEN-1:0] br_base;
  logic [XLEN-1:0] br_sum;
  logic [XLEN-1:0] br_tgt;
  logic            br_misaligned;
  logic            active;
  logic            redir;
  logic            mis_sel;
  logic [XLEN-1:0] tgt;
  logic            fire;
  logic            halting;

  // Branch/jump target; jalr clears bit 0 of the sum.
  assign br_base       = br_jalr ? br_rs1 : br_pc;
  assign br_sum        = br_base + br_imm;
  assign br_tgt        = br_jalr ? {br_sum[XLEN-1:1], 1'b0} : br_sum;
  assign br_misaligned = |(br_tgt & ALIGN_MASK);

  // Redirects are only meaningful before the generator has halted.
  assign active  = (state != HALT);
  assign fire    = pc_valid & pc_ready;
  // A halt seen now or latched during an earlier stall ends fetching at fire.
  assign halting = halt | halt_req;

  // Select the highest-priority redirect; a misaligned branch is rejected.
  always_comb begin
    redir   = 1'b0;
    mis_sel = 1'b0;
    tgt     = '0;
    if (active) begin
      if (trap_valid) begin
        redir = 1'b1;
        tgt   = trap_vec;
      end else if (mret_valid) begin
        redir = 1'b1;
        tgt   = mret_pc;
      end else if (br_valid) begin
        tgt = br_tgt;
        if (br_misaligned) begin
          mis_sel = 1'b1;
        end else begin
          redir = 1'b1;
        end
      end
    end
  end

  // Control FSM with registered handshake, PC, flush and misalign outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      pc_valid       <= 1'b0;
      pend           <= '0;
      halt_req       <= 1'b0;
      flush          <= 1'b0;
      misalign_valid <= 1'b0;
      misalign_addr  <= '0;
    end else begin
      flush          <= 1'b0;
      misalign_valid <= mis_sel;
      if (mis_sel) begin
        misalign_addr <= br_tgt;
      end
      unique case (state)
        BOOT: begin
          if (halt) begin
            state    <= HALT;
            pc_valid <= 1'b0;
          end else begin
            state    <= RUN;
            pc_valid <= 1'b1;
            if (redir) begin
              pc    <= tgt;
              flush <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fire) begin
            if (halting) begin
              state    <= HALT;
              pc_valid <= 1'b0;
              halt_req <= 1'b0;
            end else if (redir) begin
              pc    <= tgt;
              flush <= 1'b1;
            end else begin
              pc <= pc + STEP;
            end
          end else begin
            // Stalled: pc must stay put, so a redirect is parked.
            if (halt) begin
              halt_req <= 1'b1;
            end
            if (redir) begin
              pend  <= tgt;
              state <= PEND;
            end
          end
        end
        PEND: begin
          if (fire) begin
            if (halting) begin
              state    <= HALT;
              pc_valid <= 1'b0;
              halt_req <= 1'b0;
            end else begin
              pc    <= redir ? tgt : pend;
              flush <= 1'b1;
              state <= RUN;
            end
          end else begin
            if (halt) begin
              halt_req <= 1'b1;
            end
            // Latest redirect wins.
            if (redir) begin
              pend <= tgt;
            end
          end
        end
        HALT: begin
          pc_valid <= 1'b0;
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcgen_ysyx.sv
// Directed testbench for pcgen_ysyx. Two instances share stimulus:
// dut_a uses IALIGN=4, dut_b uses IALIGN=2.
module tb_pcgen_ysyx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_valid;
  logic [31:0] trap_vec;
  logic        mret_valid;
  logic [31:0] mret_pc;
  logic        br_valid;
  logic        br_jalr;
  logic [31:0] br_pc;
  logic [31:0] br_rs1;
  logic [31:0] br_imm;
  logic        halt;
  logic        pc_ready;

  logic        pc_valid_a, flush_a, mis_valid_a;
  logic [31:0] pc_a, mis_addr_a;
  logic        pc_valid_b, flush_b, mis_valid_b;
  logic [31:0] pc_b, mis_addr_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcgen_ysyx #(.XLEN(32), .RESET_PC(32'h80000000), .IALIGN(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .trap_valid(trap_valid), .trap_vec(trap_vec),
    .mret_valid(mret_valid), .mret_pc(mret_pc),
    .br_valid(br_valid), .br_jalr(br_jalr), .br_pc(br_pc),
    .br_rs1(br_rs1), .br_imm(br_imm),
    .halt(halt), .pc_ready(pc_ready),
    .pc_valid(pc_valid_a), .pc(pc_a), .flush(flush_a),
    .misalign_valid(mis_valid_a), .misalign_addr(mis_addr_a)
  );

  pcgen_ysyx #(.XLEN(32), .RESET_PC(32'h80000000), .IALIGN(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .trap_valid(trap_valid), .trap_vec(trap_vec),
    .mret_valid(mret_valid), .mret_pc(mret_pc),
    .br_valid(br_valid), .br_jalr(br_jalr), .br_pc(br_pc),
    .br_rs1(br_rs1), .br_imm(br_imm),
    .halt(halt), .pc_ready(pc_ready),
    .pc_valid(pc_valid_b), .pc(pc_b), .flush(flush_b),
    .misalign_valid(mis_valid_b), .misalign_addr(mis_addr_b)
  );

  // Advance one clock and settle past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    br_valid   = 1'b0;
    br_jalr    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (pc_a !== 32'h80000000) begin failures++; $display("FAIL reset_pc: got %h want %h", pc_a, 32'h80000000); end
    checks++; if (pc_valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", pc_valid_a); end
    checks++; if (flush_a !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b want 0", flush_a); end
    checks++; if (mis_valid_a !== 1'b0) begin failures++; $display("FAIL reset_mis_valid: got %b want 0", mis_valid_a); end
    checks++; if (mis_addr_a !== 32'h0) begin failures++; $display("FAIL reset_mis_addr: got %h want 0", mis_addr_a); end
    $display("test_reset done");
  endtask

  task automatic test_boot_seq();
    rst_n    = 1'b1;
    pc_ready = 1'b1;
    tick();
    checks++; if (pc_valid_a !== 1'b1) begin failures++; $display("FAIL boot_valid: got %b want 1", pc_valid_a); end
    checks++; if (pc_a !== 32'h80000000) begin failures++; $display("FAIL seq0: got %h want %h", pc_a, 32'h80000000); end
    checks++; if (pc_b !== 32'h80000000) begin failures++; $display("FAIL seq0_b: got %h want %h", pc_b, 32'h80000000); end
    tick();
    checks++; if (pc_a !== 32'h80000004) begin failures++; $display("FAIL seq1: got %h want %h", pc_a, 32'h80000004); end
    checks++; if (pc_b !== 32'h80000002) begin failures++; $display("FAIL seq1_b: got %h want %h", pc_b, 32'h80000002); end
    tick();
    checks++; if (pc_a !== 32'h80000008) begin failures++; $display("FAIL seq2: got %h want %h", pc_a, 32'h80000008); end
    checks++; if (flush_a !== 1'b0) begin failures++; $display("FAIL seq_flush: got %b want 0", flush_a); end
    $display("test_boot_seq done");
  endtask

  task automatic test_branch();
    br_valid = 1'b1; br_jalr = 1'b0;
    br_pc = 32'h80000010; br_imm = 32'hFFFFFFF0;
    tick();
    checks++; if (pc_a !== 32'h80000000) begin failures++; $display("FAIL br_pc: got %h want %h", pc_a, 32'h80000000); end
    checks++; if (flush_a !== 1'b1) begin failures++; $display("FAIL br_flush: got %b want 1", flush_a); end
    clear_redirects();
    tick();
    checks++; if (flush_a !== 1'b0) begin failures++; $display("FAIL br_flush_pulse: got %b want 0", flush_a); end
    checks++; if (pc_a !== 32'h80000004) begin failures++; $display("FAIL br_next: got %h want %h", pc_a, 32'h80000004); end
    $display("test_branch done");
  endtask

  task automatic test_stall_pending();
    pc_ready = 1'b0;
    br_valid = 1'b1; br_jalr = 1'b1;
    br_rs1 = 32'h80001003; br_imm = 32'h00000001;
    tick();
    checks++; if (pc_a !== 32'h80000004) begin failures++; $display("FAIL stall_hold0: got %h want %h", pc_a, 32'h80000004); end
    checks++; if (flush_a !== 1'b0) begin failures++; $display("FAIL stall_flush0: got %b want 0", flush_a); end
    clear_redirects();
    trap_valid = 1'b1; trap_vec = 32'h80002000;
    tick();
    checks++; if (pc_a !== 32'h80000004) begin failures++; $display("FAIL stall_hold1: got %h want %h", pc_a, 32'h80000004); end
    clear_redirects();
    tick();
    checks++; if (pc_a !== 32'h80000004) begin failures++; $display("FAIL stall_hold2: got %h want %h", pc_a, 32'h80000004); end
    checks++; if (pc_valid_a !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b want 1", pc_valid_a); end
    pc_ready = 1'b1;
    tick();
    checks++; if (pc_a !== 32'h80002000) begin failures++; $display("FAIL pend_pc: got %h want %h", pc_a, 32'h80002000); end
    checks++; if (flush_a !== 1'b1) begin failures++; $display("FAIL pend_flush: got %b want 1", flush_a); end
    tick();
    checks++; if (flush_a !== 1'b0) begin failures++; $display("FAIL pend_flush_pulse: got %b want 0", flush_a); end
    checks++; if (pc_a !== 32'h80002004) begin failures++; $display("FAIL pend_next: got %h want %h", pc_a, 32'h80002004); end
    $display("test_stall_pending done");
  endtask

  task automatic test_priority();
    trap_valid = 1'b1; trap_vec = 32'h80000100;
    mret_valid = 1'b1; mret_pc  = 32'h80000200;
    br_valid = 1'b1; br_jalr = 1'b0; br_pc = 32'h80000000; br_imm = 32'h00000040;
    tick();
    checks++; if (pc_a !== 32'h80000100) begin failures++; $display("FAIL prio_pc: got %h want %h", pc_a, 32'h80000100); end
    trap_valid = 1'b0;
    tick();
    checks++; if (pc_a !== 32'h80000200) begin failures++; $display("FAIL prio_mret: got %h want %h", pc_a, 32'h80000200); end
    clear_redirects();
    tick();
    checks++; if (pc_a !== 32'h80000204) begin failures++; $display("FAIL prio_next: got %h want %h", pc_a, 32'h80000204); end
    $display("test_priority done");
  endtask

  task automatic test_misalign();
    br_valid = 1'b1; br_jalr = 1'b0; br_pc = 32'h80000000; br_imm = 32'h00000006;
    tick();
    checks++; if (mis_valid_a !== 1'b1) begin failures++; $display("FAIL mis_valid: got %b want 1", mis_valid_a); end
    checks++; if (mis_addr_a !== 32'h80000006) begin failures++; $display("FAIL mis_addr: got %h want %h", mis_addr_a, 32'h80000006); end
    checks++; if (pc_a !== 32'h80000208) begin failures++; $display("FAIL mis_seq: got %h want %h", pc_a, 32'h80000208); end
    checks++; if (flush_a !== 1'b0) begin failures++; $display("FAIL mis_flush: got %b want 0", flush_a); end
    checks++; if (pc_b !== 32'h80000006) begin failures++; $display("FAIL ialign2_pc: got %h want %h", pc_b, 32'h80000006); end
    checks++; if (flush_b !== 1'b1) begin failures++; $display("FAIL ialign2_flush: got %b want 1", flush_b); end
    checks++; if (mis_valid_b !== 1'b0) begin failures++; $display("FAIL ialign2_mis: got %b want 0", mis_valid_b); end
    clear_redirects();
    tick();
    checks++; if (mis_valid_a !== 1'b0) begin failures++; $display("FAIL mis_pulse: got %b want 0", mis_valid_a); end
    checks++; if (pc_a !== 32'h8000020C) begin failures++; $display("FAIL mis_seq2: got %h want %h", pc_a, 32'h8000020C); end
    checks++; if (pc_b !== 32'h80000008) begin failures++; $display("FAIL ialign2_step: got %h want %h", pc_b, 32'h80000008); end
    $display("test_misalign done");
  endtask

  task automatic test_wrap();
    trap_valid = 1'b1; trap_vec = 32'hFFFFFFFC;
    tick();
    checks++; if (pc_a !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_tgt: got %h want %h", pc_a, 32'hFFFFFFFC); end
    clear_redirects();
    tick();
    checks++; if (pc_a !== 32'h00000000) begin failures++; $display("FAIL wrap_pc: got %h want %h", pc_a, 32'h00000000); end
    checks++; if (flush_a !== 1'b0) begin failures++; $display("FAIL wrap_flush: got %b want 0", flush_a); end
    $display("test_wrap done");
  endtask

  task automatic test_halt();
    pc_ready = 1'b0;
    halt     = 1'b1;
    tick();
    checks++; if (pc_valid_a !== 1'b1) begin failures++; $display("FAIL halt_stall_valid: got %b want 1", pc_valid_a); end
    checks++; if (pc_a !== 32'h00000000) begin failures++; $display("FAIL halt_stall_pc: got %h want %h", pc_a, 32'h00000000); end
    halt = 1'b0;
    tick();
    checks++; if (pc_valid_a !== 1'b1) begin failures++; $display("FAIL halt_wait_valid: got %b want 1", pc_valid_a); end
    pc_ready = 1'b1;
    tick();
    checks++; if (pc_valid_a !== 1'b0) begin failures++; $display("FAIL halt_valid: got %b want 0", pc_valid_a); end
    trap_valid = 1'b1; trap_vec = 32'h80004000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_valid_a !== 1'b0) begin failures++; $display("FAIL halt_stay_%0d: got %b want 0", i, pc_valid_a); end
      checks++; if (flush_a !== 1'b0) begin failures++; $display("FAIL halt_flush_%0d: got %b want 0", i, flush_a); end
    end
    clear_redirects();
    $display("test_halt done");
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    pc_ready = 1'b0;
    tick();
    checks++; if (pc_valid_a !== 1'b1) begin failures++; $display("FAIL rst2_valid: got %b want 1", pc_valid_a); end
    trap_valid = 1'b1; trap_vec = 32'h80003000;
    tick();
    clear_redirects();
    rst_n = 1'b0;
    tick();
    checks++; if (pc_valid_a !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", pc_valid_a); end
    checks++; if (pc_a !== 32'h80000000) begin failures++; $display("FAIL rst_mid_pc: got %h want %h", pc_a, 32'h80000000); end
    rst_n    = 1'b1;
    pc_ready = 1'b1;
    tick();
    checks++; if (pc_a !== 32'h80000000) begin failures++; $display("FAIL rst_mid_boot: got %h want %h", pc_a, 32'h80000000); end
    checks++; if (flush_a !== 1'b0) begin failures++; $display("FAIL rst_mid_flush: got %b want 0", flush_a); end
    tick();
    checks++; if (pc_a !== 32'h80000004) begin failures++; $display("FAIL rst_mid_lost: got %h want %h", pc_a, 32'h80000004); end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst_n = 1'b0; pc_ready = 1'b0; halt = 1'b0;
    trap_vec = '0; mret_pc = '0; br_pc = '0; br_rs1 = '0; br_imm = '0;
    clear_redirects();
    test_reset();
    test_boot_seq();
    test_branch();
    test_stall_pending();
    test_priority();
    test_misalign();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
